key_trigger_conditioner: RTL and testbench
==========================================

Name: key_trigger_conditioner

Overview:
Upstream stage of the one-hot shift counter. Converts one raw, asynchronous, bouncing pushbutton into a clean single-cycle `trigger` pulse, one per debounced press. Pipeline:
- 2-flop synchronizer
- debounce FSM
- pulse generator
- optional auto-repeat while the key is held

`trigger` drives the counter's `trigger` input directly, in the same clock domain.

Parameters:
- DB_CYCLES, 4, consecutive stable synchronized samples needed to accept a press or a release; legal range ≥1; counter width $clog2(DB_CYCLES+1).
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board KEY); 0 = active-high. The raw level is normalized to pressed=1 before the synchronizer.
- REPEAT_DELAY, 8, cycles in HELD before the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 4, cycles between later auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1, system clock; all state on posedge.
- reset, input, 1, asynchronous, active-low reset: 0 clears all state immediately; release is synchronous to clk at the board level.
- key_raw, input, 1, raw pushbutton level; asynchronous and may bounce.
- en, input, 1, pulse enable: 0 forces trigger=0, but the FSM and synchronizer keep running.
- trigger, output, 1, registered single-cycle pulse per accepted press (or per repeat).
- held, output, 1, registered; 1 while the key is debounced-pressed (states HELD and RELEASE_DB).

Behaviour:
- Reset (reset=0, async):
  - sync flops s1 and s2 = 0 (normalized not-pressed);
  - state = IDLE; db_cnt = 0; rpt_cnt = 0;
  - trigger = 0; held = 0.
- Normalization: k = KEY_ACTIVE_LOW ? ~key_raw : key_raw. Then s1 <= k and s2 <= s1. The FSM looks only at s2.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: if s2=1 → PRESS_DB with db_cnt=0. Otherwise stay.
  - PRESS_DB:
    - s2=0 → IDLE with db_cnt=0 (bounce rejected, no pulse);
    - else if db_cnt==DB_CYCLES-1 → HELD and trigger<=en;
    - else db_cnt++.
  - HELD:
    - s2=0 → RELEASE_DB with db_cnt=0;
    - otherwise stay; no further pulses unless AUTO_REPEAT_EN.
  - RELEASE_DB:
    - s2=1 → HELD with db_cnt=0 (release bounce, no new pulse);
    - else if db_cnt==DB_CYCLES-1 → IDLE;
    - else db_cnt++.
- Latency: pressed level first captured at edge E0 → trigger is high for exactly the one cycle after edge E0+DB_CYCLES+2. For DB_CYCLES=4, that is the cycle after E6.
- trigger is registered, high for exactly 1 cycle per event, and never high on two consecutive cycles.
- held = 1 in HELD and RELEASE_DB, registered alongside the state.
- Boundary conditions:
  - DB_CYCLES=1: a press is accepted on the first PRESS_DB cycle.
  - en=0 at acceptance: the press is consumed silently. Raising en later never produces a late pulse.
  - reset asserted mid-press: output drops in the same instant. After release, a still-pressed key must re-debounce from IDLE and then pulses once.
  - key held across reset release: treated as a new press.

Optional Feature:
- Macro: KEY_TRIGGER_AUTO_REPEAT_EN.
- Defined:
  - In HELD, rpt_cnt counts cycles starting from entry into HELD (including re-entry from RELEASE_DB, where it is cleared to 0).
  - First repeat pulse when rpt_cnt reaches REPEAT_DELAY.
  - Then a pulse every REPEAT_PERIOD cycles; rpt_cnt reloads so the spacing is exact.
  - Repeat pulses are gated by en. rpt_cnt is held at 0 outside HELD.
- Undefined: rpt_cnt and the repeat logic are absent; exactly one pulse per debounced press, regardless of hold time.

Test Plan:
- Press test: reset low 2 cycles, then high; key_raw (active-low) 1→0 at E0 and held, DB_CYCLES=4, en=1 → trigger=1 only in the cycle after E6; held=1 from the same cycle; trigger=0 thereafter.
- Bounce rejection: key_raw pressed for 2 cycles, released 1 cycle, repeated 3 times, then released → trigger never asserts; state returns to IDLE; held=0.
- Release bounce: while HELD, release for 2 cycles then press again → held stays 1, no second pulse. Full release ≥7 cycles → held=0. A second clean press → exactly one more pulse.
- Enable gating: en=0 during a press acceptance → no pulse. Set en=1 while still held → still no pulse. Release, then press again → one pulse.
- Async reset: reset=0 mid-HELD, not aligned to a clock edge → trigger=0 and held=0 immediately. Key still pressed at reset release → one pulse at DB_CYCLES+2 cycles after the first sampling edge.
- With KEY_TRIGGER_AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4: hold the key 30 cycles after acceptance → pulses at acceptance +0, +8, +12, +16, +20, +24, +28. Feed these into the counter stage: output walks 0001→0002→…→0080 (hex).

Source files
------------

// File: rtl/key_trigger_conditioner.sv
// Pushbutton conditioner: synchronizer, debounce FSM and single-cycle trigger pulse.
// Define KEY_TRIGGER_AUTO_REPEAT_EN to add auto-repeat pulses while the key stays held.
module key_trigger_conditioner #(
  parameter int DB_CYCLES      = 4,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_PERIOD  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  input  logic en,
  output logic trigger,
  output logic held
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  generate
    if (DB_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
      $error("key_trigger_conditioner: illegal DB_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end
  endgenerate

  logic             key_norm;
  logic [1:0]       sync_reg;
  logic             s2;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] db_cnt_reg, db_cnt_next;
  logic             trigger_reg, trigger_next;
  logic             held_reg, held_next;

  assign key_norm = KEY_ACTIVE_LOW ? ~key_raw : key_raw;
  assign s2       = sync_reg[1];
  assign trigger  = trigger_reg;
  assign held     = held_reg;

`ifdef KEY_TRIGGER_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_reg <= '0;
    end else begin
      rpt_cnt_reg <= rpt_cnt_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg    <= 2'b00;
      state_reg   <= IDLE;
      db_cnt_reg  <= '0;
      trigger_reg <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], key_norm};
      state_reg   <= state_next;
      db_cnt_reg  <= db_cnt_next;
      trigger_reg <= trigger_next;
      held_reg    <= held_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    db_cnt_next  = db_cnt_reg;
    trigger_next = 1'b0;
`ifdef KEY_TRIGGER_AUTO_REPEAT_EN
    rpt_cnt_next = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (s2) begin
          state_next  = PRESS_DB;
          db_cnt_next = '0;
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next   = HELD;
          db_cnt_next  = '0;
          trigger_next = en;
        end else begin
          db_cnt_next = db_cnt_reg + CNT_W'(1);
        end
      end
      HELD: begin
        if (!s2) begin
          state_next  = RELEASE_DB;
          db_cnt_next = '0;
        end else begin
`ifdef KEY_TRIGGER_AUTO_REPEAT_EN
          // Reload instead of clearing so later pulses are exactly REPEAT_PERIOD apart.
          if (rpt_cnt_reg == RPT_FIRE) begin
            trigger_next = en;
            rpt_cnt_next = RPT_RELOAD;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
          end
`endif
        end
      end
      RELEASE_DB: begin
        if (s2) begin
          state_next  = HELD;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        db_cnt_next = '0;
      end
    endcase
    held_next = (state_next == HELD) || (state_next == RELEASE_DB);
  end

endmodule

// File: tb/tb_key_trigger_conditioner.sv
// Scoreboard bench for key_trigger_conditioner: expected pulse cycles are queued at
// stimulus time and compared against trigger every cycle.
module tb_key_trigger_conditioner;

  localparam int DB = 4;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic key_raw = 1'b1;
  logic en      = 1'b1;
  logic trigger;
  logic held;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];

  key_trigger_conditioner #(
    .DB_CYCLES(DB),
    .KEY_ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .en(en),
    .trigger(trigger),
    .held(held)
  );

  always #5 clk = ~clk;

  // cyc is the index of the most recent rising edge
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press edge E0 is the next rising edge; the pulse is visible after edge E0+DB+2.
  task automatic press_expect();
    key_raw = 1'b0;
    exp_q.push_back(cyc + 1 + DB + 2);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      check("trigger_pulse", int'(trigger), 1);
      void'(exp_q.pop_front());
    end else begin
      check("trigger_quiet", int'(trigger), 0);
    end
  end

  initial begin
    // reset state
    @(negedge clk);
    check("rst_trigger", int'(trigger), 0);
    check("rst_held", int'(held), 0);
    @(negedge clk);
    reset = 1'b1;
    step(3);

    // clean press: held rises with the pulse, falls DB+3 cycles after release
    press_expect();
    step(6);
    check("held_before_accept", int'(held), 0);
    step(1);
    check("held_at_accept", int'(held), 1);
    step(3);
    key_raw = 1'b1;
    step(6);
    check("held_release_db", int'(held), 1);
    step(1);
    check("held_after_release", int'(held), 0);
    step(5);

    // press bounce: never DB stable samples in a row
    for (int i = 0; i < 3; i++) begin
      key_raw = 1'b0;
      step(2);
      check("held_bounce", int'(held), 0);
      key_raw = 1'b1;
      step(1);
      check("held_bounce", int'(held), 0);
    end
    step(10);
    check("held_after_bounce", int'(held), 0);

    // release bounce: held stays up, no second pulse
    press_expect();
    step(10);
    key_raw = 1'b1;
    step(2);
    key_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("held_rel_bounce", int'(held), 1);
    end
    key_raw = 1'b1;
    step(10);
    check("held_full_release", int'(held), 0);
    press_expect();
    step(10);
    key_raw = 1'b1;
    step(10);

    // enable gating: press consumed silently, raising en later adds nothing
    en = 1'b0;
    key_raw = 1'b0;
    step(8);
    check("held_en_off", int'(held), 1);
    en = 1'b1;
    step(2);
    key_raw = 1'b1;
    step(10);
    check("held_en_release", int'(held), 0);
    press_expect();
    step(10);
    key_raw = 1'b1;
    step(10);

    // async reset mid-HELD, key still pressed across reset release
    press_expect();
    step(10);
    check("held_pre_reset", int'(held), 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_held", int'(held), 0);
    check("async_trigger", int'(trigger), 0);
    step(2);
    reset = 1'b1;
    exp_q.push_back(cyc + 1 + DB + 2);
    step(10);
    check("held_after_reset", int'(held), 1);
    key_raw = 1'b1;
    step(10);

`ifdef KEY_TRIGGER_AUTO_REPEAT_EN
    begin
      int acc;
      key_raw = 1'b0;
      acc = cyc + 1 + DB + 2;
      exp_q.push_back(acc);
      for (int k = 8; k <= 28; k += 4) exp_q.push_back(acc + k);
      while (cyc < acc + 29) step(1);
      key_raw = 1'b1;
      step(10);
    end
`endif

    step(5);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
